// File: rtl/fifo_sync.sv
// Synchronous FIFO with a registered-read RAM. FWFT mode prefetches the head word into the RAM
// output register. Standard mode loads that register only when a read request is accepted.
module fifo_sync #(
   parameter int n    = 8,
   parameter int m    = 512,
   parameter int fwft = 1,
   parameter int af   = m - 4,
   parameter int ae   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               wr_valid,
   input  logic [n-1:0]       wr_data,
   output logic               wr_ready,
   input  logic               rd_ready,
   output logic               rd_valid,
   output logic [n-1:0]       rd_data,
   output logic [$clog2(m):0] level,
   output logic [2:0]         status,
   output logic               almost_full,
   output logic               almost_empty,
   output logic               ovf,
   output logic               udf
);
   localparam int AW = $clog2(m);
   localparam int LW = AW + 1;
   localparam bit FWFT = (fwft != 0);
   localparam logic [LW-1:0] FULL  = LW'(m);
   localparam logic [LW-1:0] Q1    = LW'(m / 4);
   localparam logic [LW-1:0] Q2    = LW'(m / 2);
   localparam logic [LW-1:0] Q3    = LW'((3 * m) / 4);
   localparam logic [LW-1:0] AF_TH = LW'(af);
   localparam logic [LW-1:0] AE_TH = LW'(ae);

   logic [LW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] cur_level, level_d;
   logic [2:0]    status_q, status_d;
   logic          rd_valid_q, rd_valid_d;
   logic          data_ok_q, data_ok_d;
   logic          ovf_q, ovf_d, udf_q, udf_d;
   logic          wr_acc, rd_acc, rd_avail, rd_en;
   logic [AW-1:0] raddr;
   logic [n-1:0]  mem [0:m-1];
   logic [n-1:0]  ram_q;

   always_comb begin
      cur_level = wr_ptr_q - rd_ptr_q;
      rd_avail  = FWFT ? rd_valid_q : (cur_level != '0);
      wr_acc    = wr_valid && (cur_level < FULL) && !clr;
      rd_acc    = rd_ready && rd_avail && !clr;
      wr_ptr_d  = wr_ptr_q + LW'(wr_acc);
      rd_ptr_d  = rd_ptr_q + LW'(rd_acc);
      ovf_d     = ovf_q | (wr_valid & (cur_level == FULL));
      udf_d     = udf_q | (rd_ready & ~rd_avail);
      // The prefetched word is valid only if it was already stored before this edge
      if (FWFT) begin
         rd_valid_d = cur_level > LW'(rd_acc);
      end else begin
         rd_valid_d = rd_acc;
      end
      if (clr) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         ovf_d      = 1'b0;
         udf_d      = 1'b0;
         rd_valid_d = 1'b0;
      end
      if (FWFT) begin
         data_ok_d = rd_valid_d;
      end else if (clr) begin
         data_ok_d = 1'b0;
      end else if (rd_acc) begin
         data_ok_d = 1'b1;
      end else if (rd_ready && !rd_avail) begin
         data_ok_d = 1'b0;
      end else begin
         data_ok_d = data_ok_q;
      end
      level_d = wr_ptr_d - rd_ptr_d;
      if (level_d == '0) begin
         status_d = 3'b000;
      end else if (level_d <= Q1) begin
         status_d = 3'b001;
      end else if (level_d <= Q2) begin
         status_d = 3'b010;
      end else if (level_d <= Q3) begin
         status_d = 3'b011;
      end else if (level_d < FULL) begin
         status_d = 3'b100;
      end else begin
         status_d = 3'b101;
      end
      rd_en = FWFT || rd_acc;
      raddr = FWFT ? rd_ptr_d[AW-1:0] : rd_ptr_q[AW-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         status_q   <= 3'b000;
         rd_valid_q <= 1'b0;
         data_ok_q  <= 1'b0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         status_q   <= status_d;
         rd_valid_q <= rd_valid_d;
         data_ok_q  <= data_ok_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
      end
   end

   // No reset on the storage so it maps onto block RAM
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr_q[AW-1:0]] <= wr_data;
      end
      if (rd_en) begin
         ram_q <= mem[raddr];
      end
   end

   assign level        = cur_level;
   assign status       = status_q;
   assign wr_ready     = cur_level < FULL;
   assign rd_valid     = rd_valid_q;
   assign rd_data      = data_ok_q ? ram_q : '0;
   assign almost_full  = cur_level >= AF_TH;
   assign almost_empty = cur_level <= AE_TH;
   assign ovf          = ovf_q;
   assign udf          = udf_q;
endmodule

// File: tb/tb_fifo_sync.sv
// Bench for fifo_sync with m=8: a vector table, then scoreboard-checked wrap, reset and flush sequences.
// A second instance, built with fwft=0, covers standard-mode reads.
module tb_fifo_sync;
   typedef struct {
      logic       wr_valid;
      logic [7:0] wr_data;
      logic       rd_ready;
      logic       clr;
      logic [3:0] level;
      logic [2:0] status;
      logic       wr_ready;
      logic       rd_valid;
      logic [7:0] rd_data;
      logic       af;
      logic       ae;
      logic       ovf;
      logic       udf;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clr, wr_valid, rd_ready;
   logic [7:0] wr_data;
   logic       wr_ready, rd_valid, almost_full, almost_empty, ovf, udf;
   logic [7:0] rd_data;
   logic [3:0] level;
   logic [2:0] status;

   logic       s_clr, s_wr_valid, s_rd_ready;
   logic [7:0] s_wr_data;
   logic       s_wr_ready, s_rd_valid, s_af, s_ae, s_ovf, s_udf;
   logic [7:0] s_rd_data;
   logic [3:0] s_level;
   logic [2:0] s_status;

   int         checks = 0;
   int         errors = 0;
   vec_t       vecs[$];
   logic [7:0] exp_q[$];
   logic [7:0] seq;

   fifo_sync #(.n(8), .m(8), .fwft(1)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
      .level(level), .status(status), .almost_full(almost_full),
      .almost_empty(almost_empty), .ovf(ovf), .udf(udf)
   );

   fifo_sync #(.n(8), .m(8), .fwft(0)) dut_std (
      .clk(clk), .rst_n(rst_n), .clr(s_clr),
      .wr_valid(s_wr_valid), .wr_data(s_wr_data), .wr_ready(s_wr_ready),
      .rd_ready(s_rd_ready), .rd_valid(s_rd_valid), .rd_data(s_rd_data),
      .level(s_level), .status(s_status), .almost_full(s_af),
      .almost_empty(s_ae), .ovf(s_ovf), .udf(s_udf)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mk(input logic wv, input logic [7:0] wd, input logic rr, input logic cl,
                               input logic [3:0] lv, input logic [2:0] st, input logic wrdy,
                               input logic rv, input logic [7:0] rd, input logic a_f,
                               input logic a_e, input logic ov, input logic ud);
      vec_t v;
      v.wr_valid = wv; v.wr_data = wd; v.rd_ready = rr; v.clr = cl;
      v.level = lv; v.status = st; v.wr_ready = wrdy; v.rd_valid = rv;
      v.rd_data = rd; v.af = a_f; v.ae = a_e; v.ovf = ov; v.udf = ud;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic wv, input logic [7:0] wd, input logic rr, input logic cl);
      wr_valid = wv;
      wr_data  = wd;
      rd_ready = rr;
      clr      = cl;
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      rd_ready = 1'b0;
      clr      = 1'b0;
   endtask

   task automatic stdStep(input logic wv, input logic [7:0] wd, input logic rr);
      s_wr_valid = wv;
      s_wr_data  = wd;
      s_rd_ready = rr;
      @(posedge clk);
      #1;
      s_wr_valid = 1'b0;
      s_rd_ready = 1'b0;
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, ".level"}, 32'(level), 32'd0);
      checkOutput({tag, ".status"}, 32'(status), 32'd0);
      checkOutput({tag, ".wr_ready"}, 32'(wr_ready), 32'd1);
      checkOutput({tag, ".rd_valid"}, 32'(rd_valid), 32'd0);
      checkOutput({tag, ".rd_data"}, 32'(rd_data), 32'd0);
      checkOutput({tag, ".almost_full"}, 32'(almost_full), 32'd0);
      checkOutput({tag, ".almost_empty"}, 32'(almost_empty), 32'd1);
      checkOutput({tag, ".ovf"}, 32'(ovf), 32'd0);
      checkOutput({tag, ".udf"}, 32'(udf), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      clr = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = 8'h00;
      s_clr = 1'b0; s_wr_valid = 1'b0; s_rd_ready = 1'b0; s_wr_data = 8'h00;

      //          wv  data  rr  clr  lvl st  wrdy rv data  af ae ovf udf
      vecs.push_back(mk(1, 8'h11, 0, 0, 1, 1, 1, 0, 8'h00, 0, 1, 0, 0));
      vecs.push_back(mk(1, 8'h22, 0, 0, 2, 1, 1, 1, 8'h11, 0, 1, 0, 0));
      vecs.push_back(mk(1, 8'h33, 0, 0, 3, 2, 1, 1, 8'h11, 0, 1, 0, 0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 2, 1, 1, 1, 8'h22, 0, 1, 0, 0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 1, 1, 8'h33, 0, 1, 0, 0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h00, 0, 1, 0, 0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h00, 0, 1, 0, 1));
      vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 1, 0, 8'h00, 0, 1, 0, 0));
      vecs.push_back(mk(1, 8'h40, 0, 0, 1, 1, 1, 0, 8'h00, 0, 1, 0, 0));
      vecs.push_back(mk(1, 8'h41, 0, 0, 2, 1, 1, 1, 8'h40, 0, 1, 0, 0));
      vecs.push_back(mk(1, 8'h42, 0, 0, 3, 2, 1, 1, 8'h40, 0, 1, 0, 0));
      vecs.push_back(mk(1, 8'h43, 0, 0, 4, 2, 1, 1, 8'h40, 1, 1, 0, 0));
      vecs.push_back(mk(1, 8'h44, 0, 0, 5, 3, 1, 1, 8'h40, 1, 0, 0, 0));
      vecs.push_back(mk(1, 8'h45, 0, 0, 6, 3, 1, 1, 8'h40, 1, 0, 0, 0));
      vecs.push_back(mk(1, 8'h46, 0, 0, 7, 4, 1, 1, 8'h40, 1, 0, 0, 0));
      vecs.push_back(mk(1, 8'h47, 0, 0, 8, 5, 0, 1, 8'h40, 1, 0, 0, 0));
      vecs.push_back(mk(1, 8'h48, 0, 0, 8, 5, 0, 1, 8'h40, 1, 0, 1, 0));
      vecs.push_back(mk(1, 8'h49, 1, 0, 7, 4, 1, 1, 8'h41, 1, 0, 1, 0));
      vecs.push_back(mk(1, 8'h4A, 0, 0, 8, 5, 0, 1, 8'h41, 1, 0, 1, 0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 7, 4, 1, 1, 8'h42, 1, 0, 1, 0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 6, 3, 1, 1, 8'h43, 1, 0, 1, 0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 5, 3, 1, 1, 8'h44, 1, 0, 1, 0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 4, 2, 1, 1, 8'h45, 1, 1, 1, 0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 3, 2, 1, 1, 8'h46, 0, 1, 1, 0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 2, 1, 1, 1, 8'h47, 0, 1, 1, 0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 1, 1, 8'h4A, 0, 1, 1, 0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h00, 0, 1, 1, 0));
      vecs.push_back(mk(1, 8'h55, 0, 1, 0, 0, 1, 0, 8'h00, 0, 1, 0, 0));

      #3;
      checkReset("reset");
      #9 rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].wr_valid, vecs[i].wr_data, vecs[i].rd_ready, vecs[i].clr);
         checkOutput($sformatf("v%0d.level", i), 32'(level), 32'(vecs[i].level));
         checkOutput($sformatf("v%0d.status", i), 32'(status), 32'(vecs[i].status));
         checkOutput($sformatf("v%0d.wr_ready", i), 32'(wr_ready), 32'(vecs[i].wr_ready));
         checkOutput($sformatf("v%0d.rd_valid", i), 32'(rd_valid), 32'(vecs[i].rd_valid));
         checkOutput($sformatf("v%0d.rd_data", i), 32'(rd_data), 32'(vecs[i].rd_data));
         checkOutput($sformatf("v%0d.almost_full", i), 32'(almost_full), 32'(vecs[i].af));
         checkOutput($sformatf("v%0d.almost_empty", i), 32'(almost_empty), 32'(vecs[i].ae));
         checkOutput($sformatf("v%0d.ovf", i), 32'(ovf), 32'(vecs[i].ovf));
         checkOutput($sformatf("v%0d.udf", i), 32'(udf), 32'(vecs[i].udf));
      end

      // Wrap-around: prime to level 4, then stream simultaneous write/read past the pointer wrap
      seq = 8'h00;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(seq);
         applyStimulus(1'b1, seq, 1'b0, 1'b0);
         seq++;
      end
      checkOutput("wrap.prime_level", 32'(level), 32'd4);
      for (int i = 0; i < 20; i++) begin
         checkOutput($sformatf("wrap%0d.rd_valid", i), 32'(rd_valid), 32'd1);
         checkOutput($sformatf("wrap%0d.rd_data", i), 32'(rd_data), 32'(exp_q[0]));
         void'(exp_q.pop_front());
         exp_q.push_back(seq);
         applyStimulus(1'b1, seq, 1'b1, 1'b0);
         seq++;
         checkOutput($sformatf("wrap%0d.level", i), 32'(level), 32'd4);
      end
      for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
         if (rd_valid) begin
            checkOutput("drain.rd_data", 32'(rd_data), 32'(exp_q[0]));
            void'(exp_q.pop_front());
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
         end else begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
         end
      end
      checkOutput("drain.words_left", 32'(exp_q.size()), 32'd0);
      checkOutput("drain.level", 32'(level), 32'd0);
      checkOutput("drain.udf", 32'(udf), 32'd0);

      // Asynchronous reset mid-operation at level 5
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
      end
      checkOutput("prereset.level", 32'(level), 32'd5);
      #2 rst_n = 1'b0;
      #1 checkReset("async_reset");
      #1 rst_n = 1'b1;
      applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
      checkOutput("post_reset.level", 32'(level), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("post_reset.rd_valid", 32'(rd_valid), 32'd1);
      checkOutput("post_reset.rd_data", 32'(rd_data), 32'h99);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("post_reset.drained", 32'(level), 32'd0);

      // Overflow, partial drain to level 5, then flush
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
      end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      end
      checkOutput("preclr.level", 32'(level), 32'd5);
      checkOutput("preclr.ovf", 32'(ovf), 32'd1);
      checkOutput("preclr.rd_data", 32'(rd_data), 32'h63);
      applyStimulus(1'b1, 8'hEE, 1'b1, 1'b1);
      checkOutput("clr.level", 32'(level), 32'd0);
      checkOutput("clr.ovf", 32'(ovf), 32'd0);
      checkOutput("clr.status", 32'(status), 32'd0);
      checkOutput("clr.rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("clr.rd_data", 32'(rd_data), 32'd0);

      // Standard registered-read instance
      checkOutput("std.idle_udf", 32'(s_udf), 32'd0);
      checkOutput("std.idle_ae", 32'(s_ae), 32'd1);
      stdStep(1'b0, 8'h00, 1'b1);
      checkOutput("std.empty_udf", 32'(s_udf), 32'd1);
      checkOutput("std.empty_rd_valid", 32'(s_rd_valid), 32'd0);
      checkOutput("std.empty_rd_data", 32'(s_rd_data), 32'd0);
      stdStep(1'b1, 8'hA5, 1'b0);
      checkOutput("std.wr_level", 32'(s_level), 32'd1);
      checkOutput("std.wr_status", 32'(s_status), 32'd1);
      checkOutput("std.wr_rd_valid", 32'(s_rd_valid), 32'd0);
      stdStep(1'b0, 8'h00, 1'b1);
      checkOutput("std.rd_valid", 32'(s_rd_valid), 32'd1);
      checkOutput("std.rd_data", 32'(s_rd_data), 32'hA5);
      checkOutput("std.rd_level", 32'(s_level), 32'd0);
      stdStep(1'b0, 8'h00, 1'b0);
      checkOutput("std.hold_rd_valid", 32'(s_rd_valid), 32'd0);
      checkOutput("std.hold_rd_data", 32'(s_rd_data), 32'hA5);
      stdStep(1'b0, 8'h00, 1'b1);
      checkOutput("std.udf_rd_data", 32'(s_rd_data), 32'd0);
      checkOutput("std.udf_flag", 32'(s_udf), 32'd1);
      checkOutput("std.wr_ready", 32'(s_wr_ready), 32'd1);
      checkOutput("std.af", 32'(s_af), 32'd0);
      checkOutput("std.ovf", 32'(s_ovf), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
